// File: rtl/snake_body_controller.sv
// Snake body tracker: shifts segment cells on each movement tick and flags
// apple (goodColl), wall and self (badColl) collisions on the 16x16 grid.
module snake_body_controller #(
  parameter int          MAX_LEN = 50,
  parameter logic [3:0]  INIT_X  = 4'd4,
  parameter logic [3:0]  INIT_Y  = 4'd8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    tick,
  input  logic [1:0]              dir,
  input  logic [3:0]              appleX,
  input  logic [3:0]              appleY,
  output logic [MAX_LEN-1:0][7:0] body,
  output logic [5:0]              length,
  output logic                    goodColl,
  output logic                    badColl
);

  // state | meaning
  // IDLE  | waiting for start, ticks ignored
  // RUN   | one move per tick
  // DEAD  | collision seen, frozen until reset
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;
  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

  state_t      state;
  logic [1:0]  heading;
  logic [1:0]  new_heading;
  logic [3:0]  head_x, head_y, new_x, new_y;
  logic        wall, self_hit, eat;
  logic [5:0]  new_len;
  logic [7:0]  new_tail;

  always_comb begin
    head_x      = body[0][7:4];
    head_y      = body[0][3:0];
    // opposite headings differ only in bit 0
    new_heading = (dir == {heading[1], ~heading[0]}) ? heading : dir;
    new_x       = head_x;
    new_y       = head_y;
    wall        = 1'b0;
    case (new_heading)
      UP:      begin wall = (head_y == 4'd0);  new_y = head_y - 4'd1; end
      DOWN:    begin wall = (head_y == 4'd15); new_y = head_y + 4'd1; end
      LEFT:    begin wall = (head_x == 4'd0);  new_x = head_x - 4'd1; end
      default: begin wall = (head_x == 4'd15); new_x = head_x + 4'd1; end
    endcase
    eat = ({new_x, new_y} == {appleX, appleY});

    // the tail cell only counts as occupied when the snake is growing
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((body[i] == {new_x, new_y}) &&
          ((6'(i) < length - 6'd1) || (eat && (6'(i) < length))))
        self_hit = 1'b1;
    end

    new_len  = (eat && (length != LEN_MAX)) ? length + 6'd1 : length;
    new_tail = body[0];
    for (int i = 0; i < MAX_LEN; i++) begin
      if (6'(i) == new_len - 6'd2)
        new_tail = body[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      heading  <= RIGHT;
      length   <= 6'd3;
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      body[0]  <= {INIT_X, INIT_Y};
      body[1]  <= {INIT_X - 4'd1, INIT_Y};
      for (int i = 2; i < MAX_LEN; i++)
        body[i] <= {INIT_X - 4'd2, INIT_Y};
    end else begin
      goodColl <= 1'b0;
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (tick) begin
            if (wall || self_hit) begin
              badColl <= 1'b1;
              state   <= DEAD;
            end else begin
              heading  <= new_heading;
              length   <= new_len;
              goodColl <= eat;
              body[0]  <= {new_x, new_y};
              for (int i = 1; i < MAX_LEN; i++)
                body[i] <= (6'(i) < new_len) ? body[i-1] : new_tail;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_controller.sv
// Self-checking bench for snake_body_controller: directed scenarios plus
// randomized play checked against a queue-based snake model.
module tb_snake_body_controller;
  localparam int ML = 50;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            tick = 1'b0;
  logic [1:0]      dir = 2'b11;
  logic [3:0]      appleX = 4'd0;
  logic [3:0]      appleY = 4'd0;
  logic [ML-1:0][7:0] body;
  logic [5:0]      length;
  logic            goodColl;
  logic            badColl;

  int checks = 0;
  int errors = 0;

  // model: live segments as coordinate queues, head first
  int mx[$];
  int my[$];
  int m_head;
  int m_state;  // 0 idle, 1 run, 2 dead
  bit m_good;
  bit m_bad;

  snake_body_controller #(.MAX_LEN(ML), .INIT_X(4'd4), .INIT_Y(4'd8)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
    .appleX(appleX), .appleY(appleY), .body(body), .length(length),
    .goodColl(goodColl), .badColl(badColl)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = {4, 3, 2};
    my = {8, 8, 8};
    m_head = 3;
    m_state = 0;
    m_good = 0;
    m_bad = 0;
  endtask

  task automatic model_step(bit s, bit t, int d, int ax, int ay);
    int opp[4];
    int h, nx, ny, limit;
    bit wall, eat, hit, grow;
    opp = '{1, 0, 3, 2};
    m_good = 0;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1 && t) begin
      h = (d == opp[m_head]) ? m_head : d;
      nx = mx[0];
      ny = my[0];
      case (h)
        0: ny = ny - 1;
        1: ny = ny + 1;
        2: nx = nx - 1;
        default: nx = nx + 1;
      endcase
      wall = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
      eat = !wall && (nx == ax) && (ny == ay);
      limit = eat ? mx.size() : mx.size() - 1;
      hit = 0;
      for (int k = 0; k < limit; k++)
        if (mx[k] == nx && my[k] == ny) hit = 1;
      if (wall || hit) begin
        m_bad = 1;
        m_state = 2;
      end else begin
        grow = eat && (mx.size() < ML);
        m_head = h;
        mx.push_front(nx);
        my.push_front(ny);
        if (!grow) begin
          void'(mx.pop_back());
          void'(my.pop_back());
        end
        m_good = eat;
      end
    end
  endtask

  function automatic logic [7:0] m_slot(int i);
    int j;
    j = (i < mx.size()) ? i : mx.size() - 1;
    return {4'(mx[j]), 4'(my[j])};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tick = 1'b0;
    appleX = 4'd0;
    appleY = 4'd0;
    model_reset();
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle(bit s, bit t, logic [1:0] d);
    start = s;
    tick = t;
    dir = d;
    model_step(s, t, int'(d), int'(appleX), int'(appleY));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [ML-1:0][7:0] exp;
    do_reset();
    exp = {ML{8'h28}};
    exp[0] = 8'h48;
    exp[1] = 8'h38;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b1, 2'b11);
      checks++;
      if (body !== exp) begin
        errors++;
        $display("FAIL reset_body cyc %0d got %h exp %h", c, body, exp);
      end
      checks++;
      if ({length, goodColl, badColl} !== {6'd3, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_flags got len %0d g %b b %b exp len 3 g 0 b 0", length, goodColl, badColl);
      end
    end
  endtask

  task automatic test_start_tick();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b1, 2'b11);
    exp = {ML{8'h28}};
    exp[0] = 8'h48;
    exp[1] = 8'h38;
    checks++;
    if (body !== exp) begin
      errors++;
      $display("FAIL start_tick_nomove got %h exp %h", body, exp);
    end
    cycle(1'b0, 1'b1, 2'b11);
    exp = {ML{8'h38}};
    exp[0] = 8'h58;
    exp[1] = 8'h48;
    checks++;
    if (body !== exp || length !== 6'd3) begin
      errors++;
      $display("FAIL straight_move got %h len %0d exp %h len 3", body, length, exp);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    cycle(1'b0, 1'b1, 2'b10);
    checks++;
    if (body[0] !== 8'h58) begin
      errors++;
      $display("FAIL reversal_head got %h exp 58", body[0]);
    end
    cycle(1'b0, 1'b1, 2'b01);
    checks++;
    if ({body[0], body[1], body[2]} !== 24'h595848) begin
      errors++;
      $display("FAIL turn_down got %h %h %h exp 59 58 48", body[0], body[1], body[2]);
    end
  endtask

  task automatic test_eat();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    appleX = 4'd5;
    appleY = 4'd8;
    cycle(1'b0, 1'b1, 2'b11);
    exp = {ML{8'h28}};
    exp[0] = 8'h58;
    exp[1] = 8'h48;
    exp[2] = 8'h38;
    checks++;
    if (body !== exp || length !== 6'd4 || goodColl !== 1'b1) begin
      errors++;
      $display("FAIL eat got %h len %0d g %b exp %h len 4 g 1", body, length, goodColl, exp);
    end
    cycle(1'b0, 1'b0, 2'b11);
    checks++;
    if (goodColl !== 1'b0 || length !== 6'd4) begin
      errors++;
      $display("FAIL eat_pulse got g %b len %0d exp g 0 len 4", goodColl, length);
    end
  endtask

  task automatic test_wall();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    for (int c = 0; c < 11; c++) cycle(1'b0, 1'b1, 2'b11);
    exp = {ML{8'hD8}};
    exp[0] = 8'hF8;
    exp[1] = 8'hE8;
    checks++;
    if (body !== exp || badColl !== 1'b0) begin
      errors++;
      $display("FAIL wall_approach got %h b %b exp %h b 0", body, badColl, exp);
    end
    cycle(1'b0, 1'b1, 2'b11);
    checks++;
    if (body !== exp || badColl !== 1'b1 || length !== 6'd3 || goodColl !== 1'b0) begin
      errors++;
      $display("FAIL wall_hit got %h b %b len %0d g %b exp %h b 1 len 3 g 0", body, badColl, length, goodColl, exp);
    end
    appleX = 4'd15;
    appleY = 4'd7;
    cycle(1'b1, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 2'b00);
    checks++;
    if (body !== exp || badColl !== 1'b1 || goodColl !== 1'b0) begin
      errors++;
      $display("FAIL dead_frozen got %h b %b g %b exp %h b 1 g 0", body, badColl, goodColl, exp);
    end
  endtask

  task automatic test_self();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    appleX = 4'd5; appleY = 4'd8;
    cycle(1'b0, 1'b1, 2'b11);
    appleX = 4'd6; appleY = 4'd8;
    cycle(1'b0, 1'b1, 2'b11);
    appleX = 4'd0; appleY = 4'd0;
    checks++;
    if (length !== 6'd5) begin
      errors++;
      $display("FAIL grow5 got len %0d exp 5", length);
    end
    cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 2'b10);
    cycle(1'b0, 1'b1, 2'b01);
    exp = {ML{8'h48}};
    exp[0] = 8'h57;
    exp[1] = 8'h67;
    exp[2] = 8'h68;
    exp[3] = 8'h58;
    checks++;
    if (body !== exp || badColl !== 1'b1 || length !== 6'd5) begin
      errors++;
      $display("FAIL self_hit got %h b %b len %0d exp %h b 1 len 5", body, badColl, length, exp);
    end
  endtask

  task automatic test_tail();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    appleX = 4'd5; appleY = 4'd8;
    cycle(1'b0, 1'b1, 2'b11);
    appleX = 4'd0; appleY = 4'd0;
    cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 2'b10);
    cycle(1'b0, 1'b1, 2'b01);
    exp = {ML{8'h58}};
    exp[0] = 8'h48;
    exp[1] = 8'h47;
    exp[2] = 8'h57;
    checks++;
    if (body !== exp || badColl !== 1'b0 || length !== 6'd4) begin
      errors++;
      $display("FAIL tail_chase got %h b %b len %0d exp %h b 0 len 4", body, badColl, length, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [ML-1:0][7:0] exp;
    do_reset();
    cycle(1'b1, 1'b0, 2'b11);
    appleX = 4'd5; appleY = 4'd8;
    cycle(1'b0, 1'b1, 2'b11);
    reset = 1'b0;
    #1;
    exp = {ML{8'h28}};
    exp[0] = 8'h48;
    exp[1] = 8'h38;
    checks++;
    if (body !== exp || length !== 6'd3 || goodColl !== 1'b0 || badColl !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got %h len %0d g %b b %b exp %h len 3 g 0 b 0", body, length, goodColl, badColl, exp);
    end
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(1'b0, 1'b1, 2'b11);
    checks++;
    if (body !== exp) begin
      errors++;
      $display("FAIL idle_after_reset got %h exp %h", body, exp);
    end
  endtask

  task automatic test_random();
    logic [ML-1:0][7:0] exp;
    int d, ax, ay, after_dead;
    bit s, t;
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));
      after_dead = 0;
      for (int c = 0; c < 120 && after_dead < 4; c++) begin
        d = ($urandom_range(0, 1) == 1) ? m_head : int'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) begin
          ax = mx[0] + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
          ay = my[0] + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
          if (ax < 0) ax = 0;
          if (ax > 15) ax = 15;
          if (ay < 0) ay = 0;
          if (ay > 15) ay = 15;
        end else begin
          ax = int'($urandom_range(0, 15));
          ay = int'($urandom_range(0, 15));
        end
        appleX = 4'(ax);
        appleY = 4'(ay);
        t = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 7) == 0);
        cycle(s, t, 2'(d));
        for (int i = 0; i < ML; i++) exp[i] = m_slot(i);
        checks++;
        if (body !== exp || length !== 6'(mx.size())) begin
          errors++;
          $display("FAIL rand_body ep %0d cyc %0d got %h len %0d exp %h len %0d", ep, c, body, length, exp, mx.size());
        end
        checks++;
        if (goodColl !== m_good || badColl !== m_bad) begin
          errors++;
          $display("FAIL rand_flags ep %0d cyc %0d got g %b b %b exp g %b b %b", ep, c, goodColl, badColl, m_good, m_bad);
        end
        if (m_state == 2) after_dead++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_tick();
    test_reversal();
    test_eat();
    test_wall();
    test_self();
    test_tail();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
